// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - round-robin arbiter sharing one synchronous RAM port among N_REQ requesters
// Build option ARB_FIXED_PRIO_EN: fixed priority (requester 0 highest) instead of round-robin.
module ram_port_arbiter #(
    parameter int N_REQ  = 4,
    parameter int AW     = 6,
    parameter int DW     = 8,
    parameter int RD_LAT = 2
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [N_REQ-1:0]                   req,
    input  logic [N_REQ-1:0]                   we,
    input  logic [N_REQ*AW-1:0]                addr,
    input  logic [N_REQ*DW-1:0]                wdata,
    output logic [N_REQ-1:0]                   gnt,
    output logic [AW-1:0]                      ram_addr,
    output logic [DW-1:0]                      ram_din,
    output logic                               ram_mode,
    input  logic [DW-1:0]                      ram_dout,
    output logic                               rvalid,
    output logic [DW-1:0]                      rdata,
    output logic [((N_REQ > 1) ? $clog2(N_REQ) : 1)-1:0] rid
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [IW-1:0] win;
    logic          xfer;

`ifdef ARB_FIXED_PRIO_EN
    always_comb begin
        gnt  = '0;
        win  = '0;
        xfer = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!xfer && req[k]) begin
                gnt[k] = 1'b1;
                win    = IW'(k);
                xfer   = 1'b1;
            end
        end
    end
`else
    localparam logic [IW:0] NR = (IW+1)'(N_REQ);

    logic [IW-1:0] ptr;
    logic [IW:0]   idx;

    // Search upward from ptr, wrapping at N_REQ (which need not be a power of two).
    always_comb begin
        gnt  = '0;
        win  = '0;
        xfer = 1'b0;
        idx  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = {1'b0, ptr} + (IW+1)'(k);
            if (idx >= NR) begin
                idx = idx - NR;
            end
            if (!xfer && req[idx[IW-1:0]]) begin
                gnt[idx[IW-1:0]] = 1'b1;
                win              = idx[IW-1:0];
                xfer             = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (xfer) begin
            ptr <= (win == IW'(N_REQ-1)) ? '0 : win + 1'b1;
        end
    end
`endif

    // Idle cycles issue a harmless read of the held address; ram_mode never stays high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ram_addr <= '0;
            ram_din  <= '0;
            ram_mode <= 1'b0;
        end else begin
            ram_mode <= xfer & we[win];
            if (xfer) begin
                ram_addr <= addr[win*AW +: AW];
                ram_din  <= wdata[win*DW +: DW];
            end
        end
    end

    logic [RD_LAT:0] pv;
    logic [IW-1:0]   pid [RD_LAT+1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pv <= '0;
            for (int s = 0; s <= RD_LAT; s++) begin
                pid[s] <= '0;
            end
        end else begin
            pv     <= {pv[RD_LAT-1:0], xfer & ~we[win]};
            pid[0] <= win;
            for (int s = 1; s <= RD_LAT; s++) begin
                pid[s] <= pid[s-1];
            end
        end
    end

    assign rvalid = pv[RD_LAT];
    assign rid    = pid[RD_LAT];
    assign rdata  = rvalid ? ram_dout : '0;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb/tb_ram_port_arbiter.sv - directed self-checking bench for ram_port_arbiter
module tb_ram_port_arbiter;

    localparam int N  = 4;
    localparam int AW = 6;
    localparam int DW = 8;
    localparam int RL = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [N-1:0]    req = '0;
    logic [N-1:0]    we  = '0;
    logic [N*AW-1:0] addr  = '0;
    logic [N*DW-1:0] wdata = '0;
    logic [N-1:0]    gnt;
    logic [AW-1:0]   ram_addr;
    logic [DW-1:0]   ram_din;
    logic            ram_mode;
    logic [DW-1:0]   ram_dout;
    logic            rvalid;
    logic [DW-1:0]   rdata;
    logic [1:0]      rid;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    ram_port_arbiter #(.N_REQ(N), .AW(AW), .DW(DW), .RD_LAT(RL)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .gnt(gnt), .ram_addr(ram_addr), .ram_din(ram_din), .ram_mode(ram_mode),
        .ram_dout(ram_dout), .rvalid(rvalid), .rdata(rdata), .rid(rid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM port: registers the address, then the output (2-cycle read).
    logic [DW-1:0] mem [64];
    logic [AW-1:0] ram_aq;
    always @(posedge clk) begin
        if (ram_mode) mem[ram_addr] <= ram_din;
        ram_aq   <= ram_addr;
        ram_dout <= mem[ram_aq];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h", tag, got, want);
        end
    endtask

    typedef struct {
        int            due;
        int            id;
        logic [DW-1:0] data;
    } exp_t;
    exp_t          q[$];
    logic [DW-1:0] model [64];

    // Scoreboard: returns checked at negedge, grants sampled just before posedge.
    initial forever begin
        @(negedge clk);
        if (rst) begin
            q.delete();
            check("rst_rvalid", 32'(rvalid), 0);
        end else if (q.size() > 0 && q[0].due == cyc) begin
            check("rvalid", 32'(rvalid), 1);
            check("rid", 32'(rid), 32'(q[0].id));
            check("rdata", 32'(rdata), 32'(q[0].data));
            void'(q.pop_front());
        end else begin
            check("rvalid_idle", 32'(rvalid), 0);
        end
        #4;
        if (!rst) begin
            check("gnt_onehot", 32'($onehot0(gnt)), 1);
            for (int i = 0; i < N; i++) begin
                if (gnt[i] && req[i]) begin
                    if (we[i]) model[addr[i*AW +: AW]] = wdata[i*DW +: DW];
                    else q.push_back('{due: cyc + 3, id: i, data: model[addr[i*AW +: AW]]});
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic set_port(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        we[i]            = w;
        addr[i*AW +: AW] = a;
        wdata[i*DW +: DW] = d;
    endtask

    logic [N-1:0] want_g;
    int           c0;
    logic         seen;

    initial begin
        // Reset state, with every requester asserting writes.
        #1;
        rst = 1'b1;
        req = 4'b1111;
        we  = 4'b1111;
        #2;
        check("rst_gnt", 32'(gnt), 32'h1);
        check("rst_mode", 32'(ram_mode), 0);
        check("rst_addr", 32'(ram_addr), 0);
        check("rst_din", 32'(ram_din), 0);
        check("rst_rvalid0", 32'(rvalid), 0);
        check("rst_rdata", 32'(rdata), 0);
        check("rst_rid", 32'(rid), 0);
        tick();
        check("rst_mode_held", 32'(ram_mode), 0);
        req = '0;
        we  = '0;
        tick();
        rst = 1'b0;

        // 1: 64 writes then 64 reads from requester 0.
        for (int k = 0; k < 64; k++) begin
            set_port(0, 1'b1, AW'(k), DW'(k + 5));
            req = 4'b0001;
            @(negedge clk);
            check("t1_wgnt", 32'(gnt), 32'h1);
            tick();
        end
        for (int k = 0; k < 64; k++) begin
            set_port(0, 1'b0, AW'(k), 8'h00);
            req = 4'b0001;
            @(negedge clk);
            check("t1_rgnt", 32'(gnt), 32'h1);
            tick();
        end
        req = '0;
        repeat (5) tick();

        // 2: all four requesters reading continuously.
        do_reset();
        for (int i = 0; i < N; i++) set_port(i, 1'b0, AW'(20 + i), 8'h00);
        req = 4'b1111;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
`ifdef ARB_FIXED_PRIO_EN
            want_g = 4'b0001;
`else
            want_g = 4'b0001 << (c % 4);
`endif
            check("t2_gnt", 32'(gnt), 32'(want_g));
            tick();
        end
        req = '0;
        repeat (5) tick();

        // 3: requesters 1 and 3 only, starting from ptr = 2.
        do_reset();
        set_port(1, 1'b0, AW'(30), 8'h00);
        set_port(3, 1'b0, AW'(40), 8'h00);
        req = 4'b0010;
        @(negedge clk);
        check("t3_pre", 32'(gnt), 32'h2);
        tick();
        req = 4'b1010;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
`ifdef ARB_FIXED_PRIO_EN
            want_g = 4'b0010;
`else
            want_g = (c % 2 == 0) ? 4'b1000 : 4'b0010;
`endif
            check("t3_gnt", 32'(gnt), 32'(want_g));
            tick();
        end
        req = '0;
        repeat (5) tick();

        // 4: write 0xA5 to addr 10, read it back the next cycle.
        set_port(0, 1'b1, AW'(10), 8'hA5);
        req = 4'b0001;
        @(negedge clk);
        check("t4_wgnt", 32'(gnt), 32'h1);
        tick();
        set_port(0, 1'b0, AW'(10), 8'h00);
        @(negedge clk);
        check("t4_mode_on", 32'(ram_mode), 1);
        check("t4_addr", 32'(ram_addr), 10);
        check("t4_din", 32'(ram_din), 32'hA5);
        c0 = cyc;
        tick();
        req = '0;
        @(negedge clk);
        check("t4_mode_off", 32'(ram_mode), 0);
        seen = 1'b0;
        for (int w = 0; w < 6; w++) begin
            if (!seen && rvalid) begin
                seen = 1'b1;
                check("t4_lat", 32'(cyc - c0), 3);
                check("t4_rdata", 32'(rdata), 32'hA5);
            end
            @(negedge clk);
        end
        check("t4_seen", 32'(seen), 1);
        repeat (3) tick();

        // 5: reset with three reads in flight.
        set_port(2, 1'b0, AW'(50), 8'h00);
        req = 4'b0100;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("t5_gnt", 32'(gnt), 32'h4);
            tick();
        end
        rst = 1'b1;
        req = '0;
        #1;
        check("t5_rvalid_rst", 32'(rvalid), 0);
        check("t5_mode_rst", 32'(ram_mode), 0);
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < N; i++) set_port(i, 1'b0, AW'(i), 8'h00);
        req = 4'b1111;
        @(negedge clk);
        check("t5_ptr0", 32'(gnt), 32'h1);
        #1;
        req = '0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("t5_rvalid", 32'(rvalid), 0);
            check("t5_mode", 32'(ram_mode), 0);
        end
        repeat (3) tick();

        check("drain", 32'(q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

- Round-robin arbiter that shares one port of the 64x8 synchronous dual-port RAM among `N_REQ` requesters.
- Each granted request becomes exactly one RAM command (read or write) driven on registered port pins.
- Read data returns with a requester tag after the RAM's fixed read latency.
- Instantiated once per RAM port: port A and port B each get their own arbiter.

## Interface

Parameters:
- `N_REQ`, 4: number of requesters (2..8).
- `AW`, 6: address width (64 words).
- `DW`, 8: data width.
- `RD_LAT`, 2: cycles from command on `ram_*` pins to valid `ram_dout`; the RAM registers the address, then the output.

Ports (clock and reset first):
- `clk`  in  1: single clock, all logic on posedge.
- `rst`  in  1: asynchronous, active-high reset.
- `req`  in  `N_REQ`: per-requester request, held until granted.
- `we`  in  `N_REQ`: per-requester write enable (1 = write, 0 = read).
- `addr`  in  `N_REQ*AW`: packed addresses, requester i at `[i*AW +: AW]`.
- `wdata`  in  `N_REQ*DW`: packed write data.
- `gnt`  out  `N_REQ`: one-hot grant, combinational, at most one bit high.
- `ram_addr`  out  `AW`: registered RAM address.
- `ram_din`  out  `DW`: registered RAM write data.
- `ram_mode`  out  1: registered RAM mode (1 = write, 0 = read).
- `ram_dout`  in  `DW`: RAM read data.
- `rvalid`  out  1: read data valid.
- `rdata`  out  `DW`: equals `ram_dout` while `rvalid`=1, 0 otherwise.
- `rid`  out  `$clog2(N_REQ)`: requester index of the returning read.

## Operation

Arbitration:
- `gnt` is computed combinationally from `req` and pointer `ptr`.
- The winner is the first requesting index at or after `ptr`, searching upward and wrapping from `N_REQ-1` to 0.
- A transfer occurs at a posedge with `req[i] & gnt[i]`.
- On a transfer, `ptr` loads `i+1` mod `N_REQ`. With no transfer, `ptr` holds.
- A requester keeps `req`, `we`, `addr` and `wdata` stable until it sees `gnt` high at a posedge.
- A requester may deassert `req` without penalty before it is granted.

Command register:
- On a transfer: `ram_addr`<=`addr[i]`, `ram_din`<=`wdata[i]`, `ram_mode`<=`we[i]`.
- With no transfer: `ram_mode`<=0, and `ram_addr`/`ram_din` hold. The idle read is harmless and produces no `rvalid`.
- A write therefore holds `ram_mode`=1 for exactly one cycle per write transfer.

Read return pipeline:
- The pipeline is an `RD_LAT+1`-stage shift register of {valid, id}.
- Stage 0 loads {transfer & ~`we[i]`, i}.
- The last stage drives `rvalid`/`rid`.
- One read can issue per cycle with no bubbles, so up to `RD_LAT+1` reads are in flight.

Boundary cases:
- All requesters active: strict rotation 0,1,2,3,0,… with one grant per cycle.
- Single requester active: granted every cycle, regardless of `ptr`.
- Write then read to the same address on consecutive cycles: the read returns the new data, because RAM write precedes read in port order.
- `rst` asserted mid-operation: all in-flight reads are discarded. No `rvalid` pulses after reset release for reads issued before it.

## Timing

- Cycle t: `req` high, `gnt` high combinationally.
- Posedge t: `ram_*` updated.
- Posedge t+`RD_LAT`: `rvalid`/`rid` asserted with `rdata` valid.
- Read latency from `gnt` to `rvalid`: `RD_LAT`+1 cycles, which is 3 by default.
- Reset values:
  - `ptr`=0.
  - `ram_addr`=0, `ram_din`=0, `ram_mode`=0.
  - pipeline valid bits=0.
  - `rvalid`=0, `rid`=0, `rdata`=0.
  - `gnt` follows `req` with `ptr`=0.
- `ram_mode` must be 0 throughout reset so that no spurious write occurs.

## Configuration

- `ARB_FIXED_PRIO_EN` defined:
  - Fixed priority, requester 0 highest.
  - `ptr` is removed and `gnt` selects the lowest requesting index.
  - Starvation of high indices is permitted.
- Undefined (default): round-robin as above.

## Test plan

1. Reset, then 64 write transfers from requester 0 (addr k, data k+5), then 64 reads -> `rvalid` 3 cycles after each `gnt`, `rdata`=k+5, `rid`=0.
2. All 4 requesters hold read requests continuously -> `gnt` sequence 0001, 0010, 0100, 1000 repeating; `rid` returns 0,1,2,3 in grant order, one per cycle.
3. Requesters 1 and 3 only, `ptr`=2 -> grants 3,1,3,1. No grant to an idle index.
4. Write 0xA5 to addr 10, then read addr 10 on the next cycle -> `rdata`=0xA5. `ram_mode`=1 for exactly 1 cycle.
5. Assert `rst` while 3 reads are in flight -> `rvalid`=0 for the next 4 cycles, `ptr`=0, `ram_mode`=0.
6. With `ARB_FIXED_PRIO_EN` defined and all requesters requesting -> requester 0 granted every cycle, `gnt`=0001 constant.
